// File: rtl/multi_pixel_frequency_analyzer.sv
// Samples bit 7 of NUM_CHANNELS pixel positions per line, classifies each channel's toggle
// period against two target frequencies and accumulates per-channel time spent in each mode.
`timescale 1ns/1ps
module multi_pixel_frequency_analyzer #(
    parameter int NUM_CHANNELS = 3,
    parameter int PIXEL_INDEX_WIDTH = 10,
    parameter logic [NUM_CHANNELS*PIXEL_INDEX_WIDTH-1:0] PIXEL_INDICES = {10'd1023, 10'd511, 10'd15},
    parameter int CLOCK = 100000000,
    parameter int FREQUENCY_1 = 9000,
    parameter int FREQUENCY_2 = 11000,
    parameter int FREQUENCY_DEVIATION = 10,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic [7:0]  pixel_data,
    input  logic        pixel_valid,
    input  logic        line_start,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic        busy,
    output logic        irq,
    input  logic [7:0]  reg_addr,
    output logic [31:0] reg_read_data
);

    localparam int unsigned PERIOD_1 = CLOCK / FREQUENCY_1;
    localparam int unsigned PERIOD_2 = CLOCK / FREQUENCY_2;
    localparam int unsigned DELTA_1  = PERIOD_1 * FREQUENCY_DEVIATION / 100;
    localparam int unsigned DELTA_2  = PERIOD_2 * FREQUENCY_DEVIATION / 100;
    localparam int unsigned WIN1_LO  = PERIOD_1 - DELTA_1;
    localparam int unsigned WIN1_HI  = PERIOD_1 + DELTA_1;
    localparam int unsigned WIN2_LO  = PERIOD_2 - DELTA_2;
    localparam int unsigned WIN2_HI  = PERIOD_2 + DELTA_2;
    localparam int unsigned PMAX     = (WIN1_HI > WIN2_HI) ? WIN1_HI : WIN2_HI;

    typedef logic [COUNTER_WIDTH-1:0] count_t;

    localparam count_t WIN1_LO_C = COUNTER_WIDTH'(WIN1_LO);
    localparam count_t WIN1_HI_C = COUNTER_WIDTH'(WIN1_HI);
    localparam count_t WIN2_LO_C = COUNTER_WIDTH'(WIN2_LO);
    localparam count_t WIN2_HI_C = COUNTER_WIDTH'(WIN2_HI);
    localparam count_t PMAX_C    = COUNTER_WIDTH'(PMAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        SNAPSHOT = 2'd2,
        DONE     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_F1   = 2'd1,
        MODE_F2   = 2'd2
    } mode_e;

    state_e                       state;
    state_e                       next_state;
    logic                         enter_run;
    logic [PIXEL_INDEX_WIDTH-1:0] pix_cnt;
    logic [PIXEL_INDEX_WIDTH-1:0] pix_idx;
    logic [NUM_CHANNELS-1:0]      sample;
    logic [NUM_CHANNELS-1:0]      sample_prev;
    logic [NUM_CHANNELS-1:0]      rise;
    logic [NUM_CHANNELS-1:0]      valid;
    count_t                       period_cnt [NUM_CHANNELS];
    mode_e                        mode       [NUM_CHANNELS];
    count_t                       f1_acc     [NUM_CHANNELS];
    count_t                       f2_acc     [NUM_CHANNELS];
    count_t                       f1_res     [NUM_CHANNELS];
    count_t                       f2_res     [NUM_CHANNELS];
    logic [31:0]                  read_mux;
    logic                         unused_pixel_bits;

    assign unused_pixel_bits = ^pixel_data[6:0];

    // When the two windows overlap, F1 takes precedence.
    function automatic mode_e classify(input count_t p);
        if ((p >= WIN1_LO_C) && (p <= WIN1_HI_C)) return MODE_F1;
        if ((p >= WIN2_LO_C) && (p <= WIN2_HI_C)) return MODE_F2;
        return MODE_NONE;
    endfunction

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = RUN;
            RUN:      if (stop)  next_state = SNAPSHOT;
            SNAPSHOT: next_state = DONE;
            DONE:     if (start) next_state = RUN;
            default:  next_state = IDLE;
        endcase
        if (clear) next_state = IDLE;
    end

    assign enter_run = (state != RUN) && (next_state == RUN);
    assign pix_idx   = line_start ? '0 : pix_cnt + PIXEL_INDEX_WIDTH'(1);
    assign rise      = sample & ~sample_prev;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state <= IDLE;
            busy  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN) || (next_state == SNAPSHOT);
            irq   <= (state == SNAPSHOT) && (next_state == DONE);
        end
    end

    // NOTE: the per-channel arrays are small register banks, not RAM, so they are
    // reset element by element like any other flop.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pix_cnt     <= '0;
            sample      <= '0;
            sample_prev <= '0;
            valid       <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                period_cnt[k] <= '0;
                mode[k]       <= MODE_NONE;
                f1_acc[k]     <= '0;
                f2_acc[k]     <= '0;
                f1_res[k]     <= '0;
                f2_res[k]     <= '0;
            end
        end else begin
            sample_prev <= sample;
            if (clear) begin
                valid <= '0;
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    period_cnt[k] <= '0;
                    mode[k]       <= MODE_NONE;
                    f1_acc[k]     <= '0;
                    f2_acc[k]     <= '0;
                    f1_res[k]     <= '0;
                    f2_res[k]     <= '0;
                end
            end else if (enter_run) begin
                pix_cnt <= '0;
                valid   <= '0;
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    period_cnt[k] <= '0;
                    mode[k]       <= MODE_NONE;
                    f1_acc[k]     <= '0;
                    f2_acc[k]     <= '0;
                end
            end else if (state == RUN) begin
                if (pixel_valid) begin
                    pix_cnt <= pix_idx;
                    for (int k = 0; k < NUM_CHANNELS; k++) begin
                        if (pix_idx == PIXEL_INDICES[k*PIXEL_INDEX_WIDTH +: PIXEL_INDEX_WIDTH])
                            sample[k] <= pixel_data[7];
                    end
                end
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    // The first rising edge only arms the channel; later edges close a period.
                    if (rise[k]) begin
                        period_cnt[k] <= COUNTER_WIDTH'(1);
                        if (valid[k]) mode[k]  <= classify(period_cnt[k]);
                        else          valid[k] <= 1'b1;
                    end else begin
                        if (period_cnt[k] != '1) period_cnt[k] <= period_cnt[k] + COUNTER_WIDTH'(1);
                        if (period_cnt[k] > PMAX_C) mode[k] <= MODE_NONE;
                    end
                    if ((mode[k] == MODE_F1) && (f1_acc[k] != '1))
                        f1_acc[k] <= f1_acc[k] + COUNTER_WIDTH'(1);
                    if ((mode[k] == MODE_F2) && (f2_acc[k] != '1))
                        f2_acc[k] <= f2_acc[k] + COUNTER_WIDTH'(1);
                end
            end else if (state == SNAPSHOT) begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    f1_res[k] <= f1_acc[k];
                    f2_res[k] <= f2_acc[k];
                end
            end
        end
    end

    always_comb begin
        read_mux = '0;
        if (reg_addr == 8'd0)
            read_mux = {15'b0, (state == DONE), 8'(NUM_CHANNELS), 6'b0, state};
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (reg_addr == 8'(2*k + 1)) read_mux = 32'(f1_res[k]);
            if (reg_addr == 8'(2*k + 2)) read_mux = 32'(f2_res[k]);
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) reg_read_data <= '0;
        else                  reg_read_data <= read_mux;
    end

endmodule

// File: tb/tb_multi_pixel_frequency_analyzer.sv
// Scoreboard bench for multi_pixel_frequency_analyzer: two instances (32-bit and 8-bit counters)
// share stimulus; register reads are queued when issued and compared when the read data returns.
`timescale 1ns/1ps
module tb_multi_pixel_frequency_analyzer;

    localparam int NCH = 2;
    localparam int PIW = 4;
    localparam logic [NCH*PIW-1:0] INDICES = {4'd7, 4'd3};
    localparam logic [31:0] REG0_IDLE = 32'h0000_0200;
    localparam logic [31:0] REG0_RUN  = 32'h0000_0201;
    localparam logic [31:0] REG0_DONE = 32'h0001_0203;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        line_start;
    logic        start;
    logic        stop;
    logic        clear;
    logic [7:0]  reg_addr;
    logic        busy, irq, busy8, irq8;
    logic [31:0] rdata, rdata8;

    always #5 clk = ~clk;

    multi_pixel_frequency_analyzer #(
        .NUM_CHANNELS(NCH), .PIXEL_INDEX_WIDTH(PIW), .PIXEL_INDICES(INDICES),
        .CLOCK(1000), .FREQUENCY_1(10), .FREQUENCY_2(20), .FREQUENCY_DEVIATION(10),
        .COUNTER_WIDTH(32)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .line_start(line_start), .start(start), .stop(stop),
        .clear(clear), .busy(busy), .irq(irq), .reg_addr(reg_addr), .reg_read_data(rdata)
    );

    multi_pixel_frequency_analyzer #(
        .NUM_CHANNELS(NCH), .PIXEL_INDEX_WIDTH(PIW), .PIXEL_INDICES(INDICES),
        .CLOCK(1000), .FREQUENCY_1(10), .FREQUENCY_2(20), .FREQUENCY_DEVIATION(10),
        .COUNTER_WIDTH(8)
    ) dut8 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .line_start(line_start), .start(start), .stop(stop),
        .clear(clear), .busy(busy8), .irq(irq8), .reg_addr(reg_addr), .reg_read_data(rdata8)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic        use8;
        logic [31:0] exp;
    } rd_t;

    rd_t rd_q[$];
    int  passed = 0;
    int  total = 0;
    int  irq_count = 0;
    int  irq8_count = 0;
    int  n = 0;
    int  w0_period = 0, w0_end = 0, w1_period = 0, w1_end = 0;

    always @(posedge clk) begin
        if (irq === 1'b1) irq_count++;
        if (irq8 === 1'b1) irq8_count++;
    end

    // Square wave on bit 7: high for the first half of each period, from phase until end_n.
    function automatic logic wave(input int cyc, input int period, input int phase, input int end_n);
        if (period == 0 || cyc < phase || cyc >= end_n) return 1'b0;
        return ((cyc - phase) % period) < (period / 2);
    endfunction

    // One clock of stimulus: line_start every 10 cycles, channel 0 lands on cycles 3 mod 10
    // and channel 1 on cycles 7 mod 10 (pixel counter restarts at 0 on entering RUN).
    task automatic cycle(input bit rd_en, input logic [7:0] addr, input bit use8, input logic [31:0] exp);
        rd_t         e;
        logic [31:0] got;
        pixel_valid = 1'b1;
        line_start  = (n % 10 == 0);
        pixel_data  = 8'(n * 37) & 8'h7f;
        if (n % 10 == 3) pixel_data[7] = wave(n, w0_period, 3, w0_end);
        if (n % 10 == 7) pixel_data[7] = wave(n, w1_period, 7, w1_end);
        reg_addr = rd_en ? addr : 8'h00;
        if (rd_en) begin
            e.addr = addr;
            e.use8 = use8;
            e.exp  = exp;
            rd_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rd_en) begin
            e   = rd_q.pop_front();
            got = e.use8 ? rdata8 : rdata;
            total++;
            if (got !== e.exp)
                $display("FAIL read_%s_addr%0d: got %0d (0x%08h) want %0d (0x%08h)",
                         e.use8 ? "cw8" : "cw32", e.addr, got, got, e.exp, e.exp);
            else
                passed++;
        end
        n++;
    endtask

    task automatic tick();
        cycle(1'b0, 8'h00, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [7:0] addr, input bit use8, input logic [31:0] exp);
        cycle(1'b1, addr, use8, exp);
    endtask

    task automatic begin_run();
        n     = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until(input int s);
        while (n < s) tick();
    endtask

    task automatic stop_and_wait();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        pixel_valid = 1'b0; line_start = 1'b0; pixel_data = 8'h00; reg_addr = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got 0x%08h want 0", rdata); else passed++;
        rd(8'd0, 1'b0, REG0_IDLE);
        rd(8'd0, 1'b1, REG0_IDLE);
        for (int a = 1; a <= 4; a++) rd(8'(a), 1'b0, 32'h0);
        rd(8'd9, 1'b0, 32'h0);
    endtask

    task automatic test_f1_channel0();
        int irq_base;
        w0_period = 100; w0_end = 1000000; w1_period = 0; w1_end = 0;
        irq_base = irq_count;
        begin_run();
        total++; if (busy !== 1'b1) $display("FAIL f1_busy_run: got %b want 1", busy); else passed++;
        run_until(1004);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL f1_busy_snapshot: got %b want 1", busy); else passed++;
        tick();
        total++; if (irq !== 1'b1) $display("FAIL f1_irq_done: got %b want 1", irq); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL f1_busy_done: got %b want 0", busy); else passed++;
        tick();
        total++; if (irq !== 1'b0) $display("FAIL f1_irq_after: got %b want 0", irq); else passed++;
        total++;
        if (irq_count !== irq_base + 1) $display("FAIL f1_irq_pulses: got %0d want %0d", irq_count - irq_base, 1);
        else passed++;
        rd(8'd1, 1'b0, 32'd900);
        rd(8'd2, 1'b0, 32'd0);
        rd(8'd3, 1'b0, 32'd0);
        rd(8'd4, 1'b0, 32'd0);
        rd(8'd0, 1'b0, REG0_DONE);
    endtask

    task automatic test_f2_channel1();
        int irq_base;
        w0_period = 0; w0_end = 0; w1_period = 50; w1_end = 1000000;
        irq_base = irq_count;
        begin_run();
        run_until(508);
        stop_and_wait();
        total++;
        if (irq_count !== irq_base + 1) $display("FAIL f2_irq_pulses: got %0d want %0d", irq_count - irq_base, 1);
        else passed++;
        rd(8'd4, 1'b0, 32'd450);
        rd(8'd3, 1'b0, 32'd0);
        rd(8'd1, 1'b0, 32'd0);
        rd(8'd2, 1'b0, 32'd0);
        rd(8'd4, 1'b1, 32'd255);
    endtask

    task automatic test_mode_timeout();
        w0_period = 100; w0_end = 600; w1_period = 0; w1_end = 0;
        begin_run();
        run_until(1004);
        stop_and_wait();
        rd(8'd1, 1'b0, 32'd511);
        rd(8'd2, 1'b0, 32'd0);
        rd(8'd4, 1'b0, 32'd0);
        rd(8'd1, 1'b1, 32'd255);
    endtask

    task automatic test_clear_and_start_stop();
        int irq_base;
        w0_period = 100; w0_end = 1000000; w1_period = 0; w1_end = 0;
        irq_base = irq_count;
        begin_run();
        run_until(300);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL clear_busy: got %b want 0", busy); else passed++;
        rd(8'd0, 1'b0, REG0_IDLE);
        for (int a = 1; a <= 4; a++) rd(8'(a), 1'b0, 32'h0);
        rd(8'd1, 1'b1, 32'h0);
        total++;
        if (irq_count !== irq_base) $display("FAIL clear_no_irq: got %0d want %0d", irq_count - irq_base, 0);
        else passed++;
        w0_period = 0; w0_end = 0;
        n = 0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL startstop_busy_run: got %b want 1", busy); else passed++;
        tick();
        stop = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL startstop_busy_snapshot: got %b want 1", busy); else passed++;
        tick();
        total++; if (irq !== 1'b1) $display("FAIL startstop_irq: got %b want 1", irq); else passed++;
        tick();
        total++;
        if (irq_count !== irq_base + 1) $display("FAIL startstop_irq_pulses: got %0d want %0d", irq_count - irq_base, 1);
        else passed++;
        for (int a = 1; a <= 4; a++) rd(8'(a), 1'b0, 32'h0);
        rd(8'd0, 1'b0, REG0_DONE);
    endtask

    task automatic test_saturation();
        int irq8_base;
        w0_period = 100; w0_end = 1000000; w1_period = 0; w1_end = 0;
        irq8_base = irq8_count;
        begin_run();
        run_until(1054);
        stop_and_wait();
        rd(8'd1, 1'b1, 32'd255);
        rd(8'd1, 1'b0, 32'd950);
        begin_run();
        rd(8'd1, 1'b1, 32'd255);
        rd(8'd1, 1'b0, 32'd950);
        rd(8'd0, 1'b1, REG0_RUN);
        run_until(200);
        stop_and_wait();
        rd(8'd1, 1'b1, 32'd96);
        rd(8'd1, 1'b0, 32'd96);
        total++;
        if (irq8_count !== irq8_base + 2) $display("FAIL sat_irq8_pulses: got %0d want %0d", irq8_count - irq8_base, 2);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int irq_base;
        w0_period = 100; w0_end = 1000000; w1_period = 0; w1_end = 0;
        irq_base = irq_count;
        begin_run();
        run_until(250);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL midreset_rdata: got 0x%08h want 0", rdata); else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(8'd0, 1'b0, REG0_IDLE);
        rd(8'd1, 1'b0, 32'h0);
        rd(8'd1, 1'b1, 32'h0);
        total++;
        if (irq_count !== irq_base) $display("FAIL midreset_no_irq: got %0d want %0d", irq_count - irq_base, 0);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_f1_channel0();
        test_f2_channel1();
        test_mode_timeout();
        test_clear_and_start_stop();
        test_saturation();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_pixel_frequency_analyzer.md
Name: multi_pixel_frequency_analyzer

Overview:
- Parametrised successor to the three-pixel frequency analyzer manager.
- Samples bit 7 of NUM_CHANNELS configurable pixel positions on each video line and measures each channel's toggle period. It classifies the period as FREQUENCY_1, FREQUENCY_2 or none, and accumulates per-channel action time in clock cycles.
- On stop, it snapshots the results into a register bank and pulses irq. Results are read through a simple registered read port, which an AXI slave wrapper sits in front of.

Parameters:
NUM_CHANNELS, 3, number of sampled pixels/channels (1..16)
PIXEL_INDEX_WIDTH, 10, pixel counter width
PIXEL_INDICES, {10'd1023,10'd511,10'd15}, packed indices; channel k at [k*PIXEL_INDEX_WIDTH +: PIXEL_INDEX_WIDTH]
CLOCK, 100000000, s00_axi_aclk frequency in Hz
FREQUENCY_1, 9000, first target frequency in Hz
FREQUENCY_2, 11000, second target frequency in Hz
FREQUENCY_DEVIATION, 10, tolerance in percent of nominal period
COUNTER_WIDTH, 32, period counter and accumulator width (at most 32)

Ports:
s00_axi_aclk  in  1  single clock for all logic
s00_axi_aresetn  in  1  asynchronous, active-low reset
pixel_data  in  8  pixel value, synchronous to s00_axi_aclk
pixel_valid  in  1  pixel_data qualifier
line_start  in  1  with pixel_valid, marks the pixel as index 0
start  in  1  begin measurement (level sampled per clock)
stop  in  1  end measurement
clear  in  1  synchronous clear, active-high
busy  out  1  high in RUN or SNAPSHOT
irq  out  1  one-cycle pulse when results are valid
reg_addr  in  8  register read address
reg_read_data  out  32  registered read data, latency 1

Behaviour:
- Reset (async, s00_axi_aresetn=0):
  - State IDLE.
  - All counters, accumulators, results, sample bits, busy, irq and reg_read_data are 0.
- Derived constants:
  - Pn = CLOCK/FREQUENCY_n (integer division).
  - Window n = [Pn - Pn*DEV/100, Pn + Pn*DEV/100].
  - Pmax = upper bound of the larger window.
  - If the windows overlap, F1 wins.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: stop=1 -> SNAPSHOT; start is ignored.
  - SNAPSHOT: one cycle; copies accumulators to results -> DONE.
  - DONE: start=1 -> RUN.
- Priorities: clear=1 in any state -> IDLE, and zeroes accumulators, results, period counters and mode. clear beats start/stop. start and stop together in IDLE -> RUN, and stop is then seen next cycle.
- Entering RUN: clears pixel counter, accumulators, period counters, valid flags and mode. Results are retained until the next SNAPSHOT.
- Pixel counter (RUN only):
  - On pixel_valid, the pixel's index is 0 if line_start, else counter+1. The counter stores that index.
  - Wraps modulo 2^PIXEL_INDEX_WIDTH.
  - When the index equals PIXEL_INDICES[k], sample_k <= pixel_data[7] in the same cycle.
- Per channel, RUN only:
  - Rising edge is detected on registered sample_k (sample_k=1, previous=0) at cycle t.
  - If valid_k=0: set valid_k, set period_cnt=1, mode unchanged (NONE).
  - Otherwise classify period_cnt: in window1 -> F1; in window2 -> F2; else NONE. Then set period_cnt=1.
  - The new mode is effective from cycle t+1.
  - With no edge, period_cnt increments, saturating at all-ones. When period_cnt > Pmax, mode -> NONE the next cycle.
- Accumulation: each RUN cycle with mode F1 increments f1_acc_k; F2 increments f2_acc_k. Both saturate at 2^COUNTER_WIDTH-1 with no wrap. The cycle in which stop is sampled still counts.
- Outputs:
  - irq=1 for exactly the first DONE cycle.
  - busy is registered from the state.
- Register map (reads only), data registered one cycle after reg_addr:
  - 0: {15'b0, done_flag[16], NUM_CHANNELS[15:8], 6'b0, state[1:0]}.
  - 1+2k: f1 result of channel k. 2+2k: f2 result of channel k. Zero-extended to 32 bits.
  - Unmapped addresses read 0.
- Reset mid-RUN: immediate return to IDLE with everything zero; no irq.

Test Plan:
(bench params: CLOCK=1000, FREQUENCY_1=10, FREQUENCY_2=20, DEV=10, so window1 90..110 and window2 45..55; PIXEL_INDEX_WIDTH=4, indices {7,3}, 2 channels; one pixel per clock, line_start every 10 cycles)
1. Reset, then read addr 0 -> 0x00000200; busy=0; irq=0; reads of addr 1..4 = 0.
2. Ch0 bit7 square wave with rising edges at cycles 10,110,210..., start at cycle 0, stop at 1010 -> one irq pulse at DONE; addr1=900, addr2=0, addr3=0, addr4=0.
3. Ch1 period 50 (rises at 20,70,120...), ch0 held low, stop at 520 -> addr3=450, addr4... corrected: addr4=450, addr3=0; ch0 regs 0.
4. Ch0 period 100, then toggling stops after the rise at 510; stop at 1010 -> mode drops after period_cnt exceeds 110, so addr1=400+111=511.
5. clear asserted mid-RUN at cycle 300 -> IDLE next cycle, busy=0, no irq, all results 0. Start+stop in the same IDLE cycle -> RUN, then SNAPSHOT, then irq with zero results.
6. COUNTER_WIDTH=8, ch0 period 100 for 1000 cycles -> addr1 saturates at 255. A second start clears accumulators but addr1 reads 255 until the next DONE.
